// File: rtl/rv32_e_muldiv_unit_pkg.sv
// Shared ALU control codes and mul/div state type.
// Imported by the RV32M execute-stage unit and its bench.
package rv32_e_muldiv_unit_pkg;

  localparam int ALU_CONTROL_WIDTH = 5;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_e;

  function automatic logic is_mul_op(
    input logic [4:0] op
  );
    return (op >= ALU_MUL) && (op <= ALU_MULHU);
  endfunction

  function automatic logic is_div_op(
    input logic [4:0] op
  );
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/rv32_e_div_core.sv
// Iterative radix-2 restoring unsigned divider datapath.
// One quotient bit per step; control lives in the parent.
module rv32_e_div_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [32:0] w_sh;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_sh   = {r_rem, r_quo[31]};
  assign w_ge   = w_sh >= {1'b0, r_dvs};
  // Only taken when w_sh >= divisor, so the result fits 32 bits.
  assign w_diff = w_sh[31:0] - r_dvs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (load_i) begin
      r_quo <= dividend_i;
      r_rem <= '0;
      r_dvs <= divisor_i;
    end else if (step_i) begin
      r_rem <= w_ge ? w_diff : w_sh[31:0];
      r_quo <= {r_quo[30:0], w_ge};
    end
  end

  assign quotient_o  = r_quo;
  assign remainder_o = r_rem;

endmodule

// File: rtl/rv32_e_muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit for the execute stage.
// Pipelined multiplier plus iterative divider; one-cycle done pulse.
module rv32_e_muldiv_unit
  import rv32_e_muldiv_unit_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [ALU_CONTROL_WIDTH-1:0] alu_control_i,
  input  logic [31:0]                  src_a_i,
  input  logic [31:0]                  src_b_i,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [31:0]                  result_o
);

  muldiv_state_e r_state;
  muldiv_state_e w_state_nxt;

  logic [4:0]  r_op;
  logic [32:0] r_opa;
  logic [32:0] r_opb;
  logic [5:0]  r_cnt;
  logic        r_spec;
  logic [31:0] r_spec_res;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_result;
  logic [63:0] r_prod [MUL_STAGES];

  logic        w_accept;
  logic        w_is_mul;
  logic        w_sgn_a;
  logic        w_sgn_b;
  logic        w_sdiv;
  logic        w_bzero;
  logic        w_ovf;
  logic        w_spec;
  logic [31:0] w_spec_res;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_div_res;
  logic [31:0] w_mul_res;
  logic        w_to_done;
  logic        w_div_load;
  logic        w_div_step;

  assign w_is_mul = is_mul_op(alu_control_i);
  assign w_accept = start_i && !flush_i
                 && (r_state == IDLE || r_state == DONE)
                 && (w_is_mul || is_div_op(alu_control_i));

  assign w_sgn_a = (alu_control_i == ALU_MUL)
                || (alu_control_i == ALU_MULH)
                || (alu_control_i == ALU_MULHSU);
  assign w_sgn_b = (alu_control_i == ALU_MUL)
                || (alu_control_i == ALU_MULH);

  assign w_sdiv  = (alu_control_i == ALU_DIV)
                || (alu_control_i == ALU_REM);
  assign w_bzero = src_b_i == 32'h0;
  assign w_ovf   = w_sdiv && src_a_i == 32'h8000_0000
                && src_b_i == 32'hFFFF_FFFF;
  assign w_spec  = w_bzero || w_ovf;

  always_comb begin
    w_spec_res = src_a_i;
    if (w_bzero) begin
      if (alu_control_i == ALU_DIV || alu_control_i == ALU_DIVU)
        w_spec_res = 32'hFFFF_FFFF;
    end else if (alu_control_i == ALU_DIV) begin
      w_spec_res = 32'h8000_0000;
    end else begin
      w_spec_res = 32'h0;
    end
  end

  assign w_abs_a = (w_sdiv && src_a_i[31]) ? -src_a_i : src_a_i;
  assign w_abs_b = (w_sdiv && src_b_i[31]) ? -src_b_i : src_b_i;

  // Low 64 bits of the 66-bit signed product are all any op selects.
  assign w_prod = 64'($signed(r_opa)) * 64'($signed(r_opb));

  assign w_div_load = w_accept && !w_is_mul && !w_spec;
  assign w_div_step = r_state == DIV && !r_spec && r_cnt != 6'd0;

  rv32_e_div_core u_div_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (w_div_load),
    .step_i      (w_div_step),
    .dividend_i  (w_abs_a),
    .divisor_i   (w_abs_b),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  assign w_mul_res = (r_op == ALU_MUL)
                   ? r_prod[MUL_STAGES-1][31:0]
                   : r_prod[MUL_STAGES-1][63:32];

  always_comb begin
    w_div_res = w_rem;
    unique case (1'b1)
      (r_op == ALU_DIV):  w_div_res = r_neg_q ? -w_quo : w_quo;
      (r_op == ALU_DIVU): w_div_res = w_quo;
      (r_op == ALU_REM):  w_div_res = r_neg_r ? -w_rem : w_rem;
      default:            w_div_res = w_rem;
    endcase
  end

  assign w_to_done = !flush_i
    && ((r_state == MUL && r_cnt == 6'd0)
     || (r_state == DIV && (r_spec || r_cnt == 6'd0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) w_state_nxt = w_is_mul ? MUL : DIV;
        MUL:  if (r_cnt == 6'd0) w_state_nxt = DONE;
        DIV:  if (r_spec || r_cnt == 6'd0) w_state_nxt = DONE;
        DONE: w_state_nxt = w_accept ? (w_is_mul ? MUL : DIV) : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) r_prod[i] <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= alu_control_i;
        r_opa      <= {w_sgn_a & src_a_i[31], src_a_i};
        r_opb      <= {w_sgn_b & src_b_i[31], src_b_i};
        r_cnt      <= w_is_mul ? 6'(MUL_STAGES) : 6'(DIV_ITERS);
        r_spec     <= !w_is_mul && w_spec;
        r_spec_res <= w_spec_res;
        r_neg_q    <= w_sdiv && (src_a_i[31] ^ src_b_i[31]);
        r_neg_r    <= w_sdiv && src_a_i[31];
      end else if ((r_state == MUL || r_state == DIV)
                   && r_cnt != 6'd0) begin
        r_cnt <= r_cnt - 6'd1;
      end
      if (r_state == MUL) begin
        r_prod[0] <= w_prod;
        for (int i = 1; i < MUL_STAGES; i++) r_prod[i] <= r_prod[i-1];
      end
      if (w_to_done) begin
        if (r_state == MUL) r_result <= w_mul_res;
        else                r_result <= r_spec ? r_spec_res : w_div_res;
      end
    end
  end

  assign busy_o   = r_state == MUL || r_state == DIV;
  assign done_o   = r_state == DONE;
  assign result_o = r_result;

endmodule

// File: tb/tb_rv32_e_muldiv_unit.sv
// Randomized self-checking bench for rv32_e_muldiv_unit.
// Expected results come from 64-bit integer arithmetic.
module tb_rv32_e_muldiv_unit;
  import rv32_e_muldiv_unit_pkg::*;

  localparam int MUL_STAGES = 2;
  localparam int DIV_ITERS  = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ctl = ALU_ADD;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  rv32_e_muldiv_unit #(
    .MUL_STAGES (MUL_STAGES),
    .DIV_ITERS  (DIV_ITERS)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .alu_control_i (ctl),
    .src_a_i       (src_a),
    .src_b_i       (src_b),
    .flush_i       (flush),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (op)
      ALU_MUL:    p = sa * sb;
      ALU_MULH:   p = (sa * sb) >>> 32;
      ALU_MULHSU: p = (sa * ub) >>> 32;
      ALU_MULHU:  p = longint'(64'(ua) * 64'(ub) >> 32);
      ALU_DIV:    p = (b == 0) ? -1 : sa / sb;
      ALU_DIVU:   p = (b == 0) ? -1 : ua / ub;
      ALU_REM:    p = (b == 0) ? sa : sa % sb;
      ALU_REMU:   p = (b == 0) ? ua : ua % ub;
      default:    p = 0;
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [4:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op <= ALU_MULHU) return MUL_STAGES + 1;
    if (b == 0) return 1;
    if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return DIV_ITERS + 1;
  endfunction

  task automatic run_op(input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    logic [31:0] e;
    e = ref_res(op, a, b);
    @(negedge clk);
    start = 1'b1; ctl = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency op%0d", op), n, ref_lat(op, a, b));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), result, e);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    last_exp = e;
  endtask

  task automatic launch(input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ctl = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int dcount;
    logic [4:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000);
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(ALU_DIV,    -32'sd7, 32'd2);
    run_op(ALU_REM,    -32'sd7, 32'd2);
    run_op(ALU_DIVU,   32'd7, 32'd2);
    run_op(ALU_DIVU,   32'd5, 32'd0);
    run_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op(ALU_MUL,    32'h1234_5678, 32'h9ABC_DEF0);

    for (int i = 0; i < 60; i++) begin
      op = 5'(ALU_MUL + 5'($urandom_range(0, 7)));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 17); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      run_op(op, a, b);
    end

    // Flush mid-divide: no done pulse, result keeps its value.
    launch(ALU_DIV, 32'd1000, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, last_exp);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("flush_no_done", dcount, 32'd0);

    // Flush together with start: start is dropped.
    launch(ALU_DIV, 32'd1000, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; ctl = ALU_DIVU;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; ctl = ALU_MUL;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle_busy", {31'b0, busy}, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("flush_start_no_done", dcount, 32'd0);
    check("flush_start_result", result, last_exp);

    // Non-M opcode is ignored.
    launch(ALU_ADD, 32'd3, 32'd4);
    check("nonm_busy", {31'b0, busy}, 32'd0);
    check("nonm_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    check("nonm_done2", {31'b0, done}, 32'd0);

    // Asynchronous reset mid-divide.
    launch(ALU_DIV, 32'd12345, 32'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ALU_REMU, 32'd100, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
